// File: rtl/score_keeper_pkg.sv
// score_keeper_pkg: shared pong match definitions.
// Holds the match-state encoding, player and serve-direction codes,
// the score digit width and a saturating score increment helper.
package score_keeper_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic PLAYER_L  = 1'b0;
  localparam logic PLAYER_R  = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Increment a score digit, holding at lim so the display never sees >9.
  function automatic logic [DIGIT_W-1:0] sat_inc(input logic [DIGIT_W-1:0] v,
                                                 input logic [DIGIT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/score_keeper_frame_timer.sv
// score_keeper_frame_timer: loadable 8-bit frame down-counter.
// Ports:
//   clk_0, rst    pixel clock, synchronous active-low reset
//   load          hold the counter at load_val (load wins over tick)
//   tick          frame_tick; decrements a non-zero count
//   load_val      preset value (also the reload value when AUTO_RELOAD)
//   done          combinational pulse on the tick that reaches zero
// With AUTO_RELOAD the count wraps back to load_val instead of parking at 0,
// giving a periodic done every load_val ticks.
module score_keeper_frame_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       load,
  input  logic       tick,
  input  logic [7:0] load_val,
  output logic       done
);

  logic [7:0] cnt;

  // Combinational so the owner can register its reaction one cycle after the tick.
  assign done = tick && !load && (cnt == 8'd1);

  always_ff @(posedge clk_0) begin
    if (!rst)                     cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (AUTO_RELOAD && done) cnt <= load_val;
    else if (tick && cnt != 8'd0) cnt <= cnt - 8'd1;
  end

endmodule

// File: rtl/score_keeper.sv
// score_keeper: pong match-state controller.
// Turns goal pulses into per-player scores, sequences serve / play /
// point-pause / game-over and gates ball motion.
// Ports:
//   clk_0, rst               pixel clock, synchronous active-low reset
//   frame_tick               one pulse per frame
//   goal_left / goal_right   ball left via that edge (opposite player scores)
//   serve_btn                debounced serve/start level
//   score_l / score_r        digits for the score displays
//   show_l / show_r          digit visibility (winner blinks in OVER)
//   play_en                  ball/paddles may move
//   ball_reset, serve_dir    one-cycle recentre/launch and its direction
//   game_over, winner        match finished and who won
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60,
  parameter int BLINK_FRAMES = 15
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               goal_left,
  input  logic               goal_right,
  input  logic               serve_btn,
  output logic [DIGIT_W-1:0] score_l,
  output logic [DIGIT_W-1:0] score_r,
  output logic               show_l,
  output logic               show_r,
  output logic               play_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam logic [DIGIT_W-1:0] WIN_D = DIGIT_W'(WIN_SCORE);

  state_t             state;
  logic               serve_btn_q;
  logic               serve_rise;
  logic               pause_done;
  logic               blink_done;
  logic [DIGIT_W-1:0] next_l;
  logic [DIGIT_W-1:0] next_r;

  assign serve_rise = serve_btn & ~serve_btn_q;
  assign next_l     = sat_inc(score_l, WIN_D);
  assign next_r     = sat_inc(score_r, WIN_D);

  // Each timer is held at its preset outside the state that uses it, so the
  // count always starts fresh on entry and the first in-state tick counts.
  score_keeper_frame_timer #(.AUTO_RELOAD(1'b0)) u_pause (
    .clk_0    (clk_0),
    .rst      (rst),
    .load     (state != ST_PAUSE),
    .tick     (frame_tick),
    .load_val (8'(PAUSE_FRAMES)),
    .done     (pause_done)
  );

  score_keeper_frame_timer #(.AUTO_RELOAD(1'b1)) u_blink (
    .clk_0    (clk_0),
    .rst      (rst),
    .load     (state != ST_OVER),
    .tick     (frame_tick),
    .load_val (8'(BLINK_FRAMES)),
    .done     (blink_done)
  );

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state       <= ST_IDLE;
      serve_btn_q <= 1'b1;  // a button held through reset is not a press
      score_l     <= '0;
      score_r     <= '0;
      show_l      <= 1'b1;
      show_r      <= 1'b1;
      play_en     <= 1'b0;
      ball_reset  <= 1'b0;
      serve_dir   <= DIR_LEFT;
      game_over   <= 1'b0;
      winner      <= PLAYER_L;
    end else begin
      serve_btn_q <= serve_btn;
      ball_reset  <= 1'b0;
      case (state)
        ST_IDLE: if (serve_rise) begin
          ball_reset <= 1'b1;
          serve_dir  <= DIR_LEFT;
          play_en    <= 1'b1;
          state      <= ST_PLAY;
        end
        ST_PLAY: begin
          if (goal_left && goal_right) begin
            // Simultaneous exit: no point awarded, just re-serve after the pause.
            play_en <= 1'b0;
            state   <= ST_PAUSE;
          end else if (goal_left) begin
            score_r   <= next_r;
            serve_dir <= DIR_LEFT;
            play_en   <= 1'b0;
            if (next_r == WIN_D) begin
              game_over <= 1'b1;
              winner    <= PLAYER_R;
              state     <= ST_OVER;
            end else begin
              state <= ST_PAUSE;
            end
          end else if (goal_right) begin
            score_l   <= next_l;
            serve_dir <= DIR_RIGHT;
            play_en   <= 1'b0;
            if (next_l == WIN_D) begin
              game_over <= 1'b1;
              winner    <= PLAYER_L;
              state     <= ST_OVER;
            end else begin
              state <= ST_PAUSE;
            end
          end
        end
        ST_PAUSE: if (pause_done) begin
          ball_reset <= 1'b1;
          play_en    <= 1'b1;
          state      <= ST_PLAY;
        end
        ST_OVER: begin
          if (serve_rise) begin
            score_l    <= '0;
            score_r    <= '0;
            show_l     <= 1'b1;
            show_r     <= 1'b1;
            game_over  <= 1'b0;
            serve_dir  <= ~winner;  // loser receives the first serve
            ball_reset <= 1'b1;
            play_en    <= 1'b1;
            state      <= ST_PLAY;
          end else if (blink_done) begin
            if (winner == PLAYER_R) show_r <= ~show_r;
            else                    show_l <= ~show_l;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper.
// Each driven cycle runs a behavioural match model and queues the expected
// outputs; a monitor pops them just after the next clock edge and compares.
module tb_score_keeper;

  localparam int WIN   = 9;
  localparam int PAUSE = 60;
  localparam int BLINK = 15;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       goal_left = 1'b0;
  logic       goal_right = 1'b0;
  logic       serve_btn = 1'b1;
  logic [3:0] score_l, score_r;
  logic       show_l, show_r, play_en, ball_reset, serve_dir, game_over, winner;

  score_keeper #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PAUSE), .BLINK_FRAMES(BLINK)) dut (
    .clk_0      (clk_0),
    .rst        (rst),
    .frame_tick (frame_tick),
    .goal_left  (goal_left),
    .goal_right (goal_right),
    .serve_btn  (serve_btn),
    .score_l    (score_l),
    .score_r    (score_r),
    .show_l     (show_l),
    .show_r     (show_r),
    .play_en    (play_en),
    .ball_reset (ball_reset),
    .serve_dir  (serve_dir),
    .game_over  (game_over),
    .winner     (winner)
  );

  always #5 clk_0 = ~clk_0;

  typedef struct packed {
    logic [3:0] sl, sr;
    logic shl, shr, play, br, dir, go, win;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Reference match model
  typedef enum {M_IDLE, M_PLAY, M_PAUSE, M_OVER} mst_t;
  mst_t m_st = M_IDLE;
  int   m_sl = 0, m_sr = 0, m_pt = 0, m_bt = 0;
  logic m_shl = 1, m_shr = 1, m_play = 0, m_br = 0, m_dir = 0, m_go = 0, m_win = 0;
  logic m_btnq = 1;

  task automatic model(input logic r, ft, gl, gr, sb);
    logic rise;
    if (!r) begin
      m_st = M_IDLE; m_sl = 0; m_sr = 0; m_pt = 0; m_bt = 0;
      m_shl = 1; m_shr = 1; m_play = 0; m_br = 0; m_dir = 0; m_go = 0; m_win = 0;
      m_btnq = 1;
    end else begin
      rise   = sb & ~m_btnq;
      m_btnq = sb;
      m_br   = 0;
      case (m_st)
        M_IDLE: if (rise) begin m_br = 1; m_dir = 0; m_play = 1; m_st = M_PLAY; end
        M_PLAY: begin
          if (gl && gr) begin
            m_play = 0; m_pt = 0; m_st = M_PAUSE;
          end else if (gl) begin
            if (m_sr < WIN) m_sr++;
            m_dir = 0; m_play = 0;
            if (m_sr == WIN) begin m_go = 1; m_win = 1; m_bt = 0; m_st = M_OVER; end
            else begin m_pt = 0; m_st = M_PAUSE; end
          end else if (gr) begin
            if (m_sl < WIN) m_sl++;
            m_dir = 1; m_play = 0;
            if (m_sl == WIN) begin m_go = 1; m_win = 0; m_bt = 0; m_st = M_OVER; end
            else begin m_pt = 0; m_st = M_PAUSE; end
          end
        end
        M_PAUSE: if (ft) begin
          m_pt++;
          if (m_pt == PAUSE) begin m_br = 1; m_play = 1; m_st = M_PLAY; end
        end
        M_OVER: begin
          if (rise) begin
            m_sl = 0; m_sr = 0; m_shl = 1; m_shr = 1; m_go = 0;
            m_dir = ~m_win; m_br = 1; m_play = 1; m_st = M_PLAY;
          end else if (ft) begin
            m_bt++;
            if (m_bt % BLINK == 0) begin
              if (m_win) m_shr = ~m_shr;
              else       m_shl = ~m_shl;
            end
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input logic r, ft, gl, gr, sb);
    exp_t e;
    @(negedge clk_0);
    rst = r; frame_tick = ft; goal_left = gl; goal_right = gr; serve_btn = sb;
    model(r, ft, gl, gr, sb);
    e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.shl = m_shl; e.shr = m_shr; e.play = m_play;
    e.br = m_br; e.dir = m_dir; e.go = m_go; e.win = m_win;
    exp_q.push_back(e);
  endtask

  // n frames, one frame_tick every third cycle
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
    end
  endtask

  task automatic press();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
  endtask

  always @(posedge clk_0) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("score_l",    score_l,           e.sl);
      chk("score_r",    score_r,           e.sr);
      chk("show_l",     {3'b0, show_l},     {3'b0, e.shl});
      chk("show_r",     {3'b0, show_r},     {3'b0, e.shr});
      chk("play_en",    {3'b0, play_en},    {3'b0, e.play});
      chk("ball_reset", {3'b0, ball_reset}, {3'b0, e.br});
      chk("serve_dir",  {3'b0, serve_dir},  {3'b0, e.dir});
      chk("game_over",  {3'b0, game_over},  {3'b0, e.go});
      chk("winner",     {3'b0, winner},     {3'b0, e.win});
    end
  end

  initial begin
    // Reset with serve held high, then release: no start until a fresh rise.
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (4) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);   // start
    repeat (3) step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    // Right edge exit: left scores, pause, with ignored inputs during pause.
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 1, 1, 1, 0);
    frames(PAUSE + 2);
    // Simultaneous goals: no score, pause, serve_dir unchanged.
    step(1, 0, 1, 1, 0);
    frames(PAUSE + 2);
    // Right player to the winning score.
    for (int p = 0; p < WIN; p++) begin
      step(1, 0, 1, 0, 0);
      frames(PAUSE + 1);
    end
    // Game over: blink for a while, extra goals ignored.
    step(1, 0, 1, 0, 0);
    frames(4 * BLINK + 3);
    step(1, 0, 0, 1, 0);
    frames(BLINK);
    // New game from OVER, then reset mid-pause.
    press();
    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    frames(10);
    step(0, 1, 0, 0, 1);
    repeat (3) step(1, 0, 0, 0, 1);
    press();
    frames(3);
    @(posedge clk_0);
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
Match-state controller for the pong game. It converts goal pulses from the ball logic into per-player scores, sequences serve, play, point-pause and game-over, and gates ball motion. Its outputs drive the two score_display instances (one digit 0-9 per player) and the ball/paddle engine. It runs in the pixel clock domain and is paced by a one-per-frame tick.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..9 (single-digit display)
PAUSE_FRAMES, 60, frames ball is frozen after a point (1..255)
BLINK_FRAMES, 15, frames per on/off phase of winner's digit in OVER (1..255)

Ports:
clk_0  in  1  25.175 MHz pixel clock
rst  in  1  synchronous, active-low reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
goal_left  in  1  one-cycle pulse: ball exited left edge (right player scores)
goal_right  in  1  one-cycle pulse: ball exited right edge (left player scores)
serve_btn  in  1  debounced serve/start button, active-high level
score_l  out  4  left player score, to score_display number
score_r  out  4  right player score, to score_display number
show_l  out  1  left digit visible; ANDed with that display's pixel_on
show_r  out  1  right digit visible
play_en  out  1  1 = ball/paddles move
ball_reset  out  1  one-cycle pulse: recentre ball and launch
serve_dir  out  1  launch direction at ball_reset: 0 = toward left, 1 = toward right
game_over  out  1  1 while in OVER
winner  out  1  0 = left won, 1 = right won; valid while game_over

Behaviour:
- All outputs registered. Reset values: scores 0, show_l/show_r 1, play_en 0, ball_reset 0, serve_dir 0, game_over 0, winner 0, state IDLE, counters 0, serve_btn_q 1.
- serve_rise = serve_btn & ~serve_btn_q. serve_btn_q resets to 1, so a button held through reset does not start a game.
- IDLE: play_en 0. On serve_rise: ball_reset pulses next cycle, serve_dir 0, go to PLAY.
- PLAY: play_en 1.
  - goal_left alone: score_r+1, serve_dir 0 (serve toward the conceding player).
  - goal_right alone: score_l+1, serve_dir 1.
  - Both in the same cycle: no score change, serve_dir unchanged, go to PAUSE.
  - After an increment: if the new score == WIN_SCORE, go to OVER and set winner. Otherwise go to PAUSE and load pause_cnt = PAUSE_FRAMES.
  - play_en drops the cycle after the goal pulse.
- PAUSE: play_en 0. Each frame_tick decrements pause_cnt. On the tick that takes it to 0: ball_reset pulses one cycle, go to PLAY. Duration is exactly PAUSE_FRAMES frame_ticks.
- OVER: play_en 0, game_over 1.
  - The winner's show_* toggles on every BLINK_FRAMES-th frame_tick. The first toggle sets it to 0. The loser's show_* stays 1.
  - On serve_rise: scores 0, show_l/show_r 1, game_over 0, serve_dir = ~winner (serve toward the loser), ball_reset pulses, go to PLAY.
- Goal pulses outside PLAY are ignored. serve_rise outside IDLE/OVER is ignored.
- Scores saturate at WIN_SCORE; values above 9 are never produced.
- rst low takes priority in any state mid-operation and returns all outputs to reset values the next edge.
- State/score changes occur one clk_0 after the triggering input. ball_reset is never asserted for more than 1 cycle.

Decomposition:
- Shared include pong_defs.vh holds:
  - state encodings ST_IDLE, ST_PLAY, ST_PAUSE, ST_OVER (2-bit)
  - PLAYER_L=0, PLAYER_R=1
  - DIR_LEFT=0, DIR_RIGHT=1
  - digit width 4
- One sub-module, frame_timer: loadable 8-bit down-counter advanced by frame_tick, with a one-cycle done pulse on reaching 0. Used once for pause and once for blink (auto-reload).

Test Plan:
- Reset with serve_btn held high, release, press -> no start until the rising edge. Then ball_reset is 1 for exactly 1 cycle, play_en=1, serve_dir=0.
- In PLAY, goal_right pulse -> next cycle score_l=1, play_en=0, serve_dir=1. After 60 frame_ticks, ball_reset pulses on the cycle after the 60th tick and play_en=1.
- goal_left and goal_right in the same cycle -> scores unchanged (0,0), PAUSE entered, serve_dir unchanged.
- Goal pulses and serve presses during PAUSE -> no score change, no early resume.
- Drive right player to 9 (nine goal_left pulses, each followed by the pause) -> score_r=9, game_over=1, winner=1. show_r toggles every 15 frame_ticks; show_l stays 1. A further goal_left leaves score_r at 9.
- In OVER, serve press -> scores 0/0, show_l/show_r 1, game_over 0, serve_dir=0, ball_reset pulse. Asserting rst mid-PAUSE -> all outputs at reset values next edge.
